// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate-generation stage: RV opcodes,
// the 3-bit format tag and the skid-buffer occupancy encoding.
package imm_gen_pkg;

  localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6
  } fmt_t;

  // Occupancy of the output register + skid entry
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decoder: ir -> {imm, fmt, illegal, pcrel}.
// Optional macro IMM_GEN_ZICSR_EN: CSR*I instructions emit the 5-bit zimm
// with tag Z instead of the I-format immediate.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_ir,
  output logic [XLEN-1:0] o_imm,
  output fmt_t            o_fmt,
  output logic            o_illegal,
  output logic            o_pcrel
);

  logic [31:0] w_imm32;

  // Build the 32-bit immediate; every format's top bit is either ir[31]
  // or a zero (U low bits, zimm), so one sign-extension covers XLEN=64.
  always_comb begin
    w_imm32   = '0;
    o_fmt     = FMT_R;
    o_illegal = 1'b0;
    o_pcrel   = 1'b0;
    case (i_ir[6:0])
      OPC_ARITH_I, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
        w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
        o_fmt   = FMT_I;
      end
      OPC_SYSTEM: begin
        w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
        o_fmt   = FMT_I;
`ifdef IMM_GEN_ZICSR_EN
        if (i_ir[14]) begin
          w_imm32 = {27'b0, i_ir[19:15]};
          o_fmt   = FMT_Z;
        end
`endif
      end
      OPC_STORE: begin
        w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
        o_fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        w_imm32 = {{20{i_ir[31]}}, i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
        o_fmt   = FMT_B;
        o_pcrel = 1'b1;
      end
      OPC_LUI: begin
        w_imm32 = {i_ir[31:12], 12'b0};
        o_fmt   = FMT_U;
      end
      OPC_AUIPC: begin
        w_imm32 = {i_ir[31:12], 12'b0};
        o_fmt   = FMT_U;
        o_pcrel = 1'b1;
      end
      OPC_JAL: begin
        w_imm32 = {{12{i_ir[31]}}, i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
        o_fmt   = FMT_J;
        o_pcrel = 1'b1;
      end
      OPC_OP: ;
      // Unknown opcodes, including any with ir[1:0] != 2'b11
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// in_ready depends only on the occupancy register, so there is no
// combinational out_ready -> in_ready path.
// Optional macro IMM_GEN_ZICSR_EN (see imm_decode_comb).
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [XLEN-1:0] w_imm;
  fmt_t            w_fmt;
  logic            w_illegal;
  logic            w_pcrel;
  logic [XLEN-1:0] w_target;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_out_imm,  r_skid_imm;
  logic [2:0]      r_out_fmt,  r_skid_fmt;
  logic            r_out_ill,  r_skid_ill;
  logic [XLEN-1:0] r_out_tgt,  r_skid_tgt;

  logic w_in_xfer, w_out_xfer, w_load_out, w_load_skid, w_skid_to_out;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .i_ir      (in_ir),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal),
    .o_pcrel   (w_pcrel)
  );

  // JALR is not pc-relative here; its register-relative target is formed later
  assign w_target = in_pc + (w_pcrel ? w_imm : XLEN'(4));

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);

  assign w_in_xfer     = in_valid & in_ready;
  assign w_out_xfer    = out_valid & out_ready;
  assign w_load_out    = w_in_xfer & ((r_state == ST_EMPTY) | w_out_xfer);
  assign w_load_skid   = w_in_xfer & (r_state == ST_ONE) & ~w_out_xfer;
  assign w_skid_to_out = (r_state == ST_FULL) & w_out_xfer;

  // Occupancy FSM; reset wins over any transfer and drops in-flight entries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer)      r_state <= ST_FULL;
          else if (!w_in_xfer && w_out_xfer) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_out_xfer) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  // Output registers (except target): fresh decode or the parked skid entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_imm <= '0;
      r_out_fmt <= '0;
      r_out_ill <= 1'b0;
    end else if (w_load_out) begin
      r_out_imm <= w_imm;
      r_out_fmt <= w_fmt;
      r_out_ill <= w_illegal;
    end else if (w_skid_to_out) begin
      r_out_imm <= r_skid_imm;
      r_out_fmt <= r_skid_fmt;
      r_out_ill <= r_skid_ill;
    end
  end

  generate
    if (RESET_PC_ZERO) begin : g_tgt_rst
      // Target register with reset to zero
      always_ff @(posedge clk) begin
        if (rst)                r_out_tgt <= '0;
        else if (w_load_out)    r_out_tgt <= w_target;
        else if (w_skid_to_out) r_out_tgt <= r_skid_tgt;
      end
    end else begin : g_tgt_norst
      // Data-only target register, no reset
      always_ff @(posedge clk) begin
        if (w_load_out)         r_out_tgt <= w_target;
        else if (w_skid_to_out) r_out_tgt <= r_skid_tgt;
      end
    end
  endgenerate

  // Skid entry parks an input accepted while the output is stalled
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_imm <= w_imm;
      r_skid_fmt <= w_fmt;
      r_skid_ill <= w_illegal;
      r_skid_tgt <= w_target;
    end
  end

  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_illegal = r_out_ill;
  assign out_target  = r_out_tgt;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage (XLEN=32): driver pushes expected
// results on each accepted input, a monitor pops/compares on each output
// transfer and checks hold-stability while stalled.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_ir, in_pc, out_imm, out_target;
  logic [2:0]  out_fmt;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .RESET_PC_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target),
    .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  logic use_dir = 1'b0;
  exp_t dir_exp;
  logic rnd_en = 1'b0;

  // Reference model: immediates assembled arithmetically from field values
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] pc);
    exp_t e;
    logic [31:0] s;
    logic rel;
    e = '0;
    rel = 1'b0;
    s = ir[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ir[6:0])
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
        e.imm = (s << 12) | (ir >> 20); e.fmt = 3'd1;
      end
      7'h23: begin
        e.imm = (s << 12) | ((ir >> 25) << 5) | ((ir >> 7) & 32'd31); e.fmt = 3'd2;
      end
      7'h63: begin
        e.imm = (s << 12) | (((ir >> 7) & 32'd1) << 11) | (((ir >> 25) & 32'd63) << 5)
              | (((ir >> 8) & 32'd15) << 1);
        e.fmt = 3'd3; rel = 1'b1;
      end
      7'h37, 7'h17: begin
        e.imm = ir & 32'hFFFF_F000; e.fmt = 3'd4; rel = (ir[6:0] == 7'h17);
      end
      7'h6F: begin
        e.imm = (s << 20) | (((ir >> 12) & 32'd255) << 12) | (((ir >> 20) & 32'd1) << 11)
              | (((ir >> 21) & 32'd1023) << 1);
        e.fmt = 3'd5; rel = 1'b1;
      end
      7'h33: ;
      default: e.ill = 1'b1;
    endcase
`ifdef IMM_GEN_ZICSR_EN
    if (ir[6:0] == 7'h73 && ir[14]) begin
      e.imm = (ir >> 15) & 32'd31; e.fmt = 3'd6;
    end
`endif
    e.tgt = pc + (rel ? e.imm : 32'd4);
    return e;
  endfunction

  function automatic logic [31:0] gen_ir();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 12);
    case (k)
      0: r[6:0] = 7'h13;  1: r[6:0] = 7'h03;  2: r[6:0] = 7'h23;
      3: r[6:0] = 7'h63;  4: r[6:0] = 7'h37;  5: r[6:0] = 7'h17;
      6: r[6:0] = 7'h6F;  7: r[6:0] = 7'h67;  8: r[6:0] = 7'h73;
      9: r[6:0] = 7'h0F; 10: r[6:0] = 7'h33;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard push: one expected entry per accepted input
  initial forever begin
    @(negedge clk);
    if (!rst && in_valid && in_ready)
      q.push_back(use_dir ? dir_exp : model(in_ir, in_pc));
  end

  // Monitor: compare on output transfer, check hold while stalled
  initial begin
    exp_t e;
    logic [68:0] snap;
    logic snap_v;
    snap_v = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        snap_v = 1'b0;
      end else begin
        if (snap_v) begin
          checks++;
          if ({out_valid, out_imm, out_fmt, out_target, out_illegal} !== snap) begin
            errors++;
            $display("FAIL hold_stable: got %0h expected %0h",
                     {out_valid, out_imm, out_fmt, out_target, out_illegal}, snap);
          end
        end
        snap_v = out_valid && !out_ready;
        snap   = {out_valid, out_imm, out_fmt, out_target, out_illegal};
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got imm=%h fmt=%0d tgt=%h ill=%b with nothing expected",
                     out_imm, out_fmt, out_target, out_illegal);
          end else begin
            e = q.pop_front();
            if (out_imm !== e.imm || out_fmt !== e.fmt || out_target !== e.tgt ||
                out_illegal !== e.ill) begin
              errors++;
              $display("FAIL scoreboard: got imm=%h fmt=%0d tgt=%h ill=%b expected imm=%h fmt=%0d tgt=%h ill=%b",
                       out_imm, out_fmt, out_target, out_illegal, e.imm, e.fmt, e.tgt, e.ill);
            end
          end
        end
      end
    end
  end

  // Random back-pressure during the random phase
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] ir, input logic [31:0] pc);
    int n;
    logic acc;
    n = 0;
    in_valid = 1'b1; in_ir = ir; in_pc = pc;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept after %0d cycles expected accept", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic dsend(input logic [31:0] ir, input logic [31:0] pc, input exp_t e);
    use_dir = 1'b1; dir_exp = e;
    send(ir, pc);
    use_dir = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_imm",       64'(out_imm), 64'd0);
    chk("rst_fmt",       64'(out_fmt), 64'd0);
    chk("rst_illegal",   64'(out_illegal), 64'd0);
    chk("rst_target",    64'(out_target), 64'd0);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations
    out_ready = 1'b1;
    dsend(32'hFFF00093, 32'h100, '{imm:32'hFFFFFFFF, fmt:3'd1, tgt:32'h104, ill:1'b0});
    chk("latency_1", 64'(out_valid), 64'd1);
    dsend(32'hFE112E23, 32'h200, '{imm:32'hFFFFFFFC, fmt:3'd2, tgt:32'h204, ill:1'b0});
    dsend(32'hFE000CE3, 32'h100, '{imm:32'hFFFFFFF8, fmt:3'd3, tgt:32'h0F8, ill:1'b0});
    dsend(32'h123452B7, 32'h100, '{imm:32'h12345000, fmt:3'd4, tgt:32'h104, ill:1'b0});
    dsend(32'h0000007F, 32'h300, '{imm:32'h0, fmt:3'd0, tgt:32'h304, ill:1'b1});
    dsend(32'h00000010, 32'h600, '{imm:32'h0, fmt:3'd0, tgt:32'h604, ill:1'b1});
`ifdef IMM_GEN_ZICSR_EN
    dsend(32'h3401D073, 32'h400, '{imm:32'h3, fmt:3'd6, tgt:32'h404, ill:1'b0});
`else
    dsend(32'h3401D073, 32'h400, '{imm:32'h340, fmt:3'd1, tgt:32'h404, ill:1'b0});
`endif
    dsend(32'h0080006F, 32'hFFFFFFFC, '{imm:32'h8, fmt:3'd5, tgt:32'h4, ill:1'b0});
    dsend(32'h00001017, 32'h10, '{imm:32'h1000, fmt:3'd4, tgt:32'h1010, ill:1'b0});
    dsend(32'h002081B3, 32'h500, '{imm:32'h0, fmt:3'd0, tgt:32'h504, ill:1'b0});
    dsend(32'hFFC08067, 32'h700, '{imm:32'hFFFFFFFC, fmt:3'd1, tgt:32'h704, ill:1'b0});
    drain();

    // Back-pressure: two accepts fill the stage, third waits
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h10);
    send(32'hFE112E23, 32'h20);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_ir = 32'hFE000CE3; in_pc = 32'h30;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_in_ready_held", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    send(32'hFE000CE3, 32'h30);
    drain();

    // Reset while FULL drops everything
    out_ready = 1'b0;
    send(32'h123452B7, 32'h40);
    send(32'h0080006F, 32'h50);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready",  64'(in_ready), 64'd1);
    q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);

    // Random traffic with random back-pressure
    rnd_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(gen_ir(), $urandom());
    end
    rnd_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised successor to the combinational immediate generator. Sits between fetch and decode/execute.
- Accepts one instruction plus PC per valid/ready handshake. Returns:
  - the sign-extended immediate at XLEN width;
  - a format tag;
  - a precomputed PC-relative target;
  - an illegal-opcode flag.
- A 2-entry skid buffer lets in_ready be driven purely from registers, so there is no combinational path from out_ready to in_ready.

Parameters:
- XLEN, 32, datapath width for imm/pc/target; legal values 32 or 64.
- RESET_PC_ZERO, 1, when 1 the out_target register clears to 0 on reset; when 0 it is left unreset (data-only register).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept (registered)
- in_ir  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format tag: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm)
- out_target  out  XLEN  in_pc + imm for B/J/AUIPC; otherwise in_pc + 4
- out_illegal  out  1  opcode not recognised

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, in_ready=1, state=EMPTY.
  - out_imm=0, out_fmt=0, out_illegal=0.
  - out_target=0 only if RESET_PC_ZERO=1.
  - Skid contents are don't-care.
- Transfer rules:
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - Latency 1 cycle: an input accepted in cycle N appears on out_* in cycle N+1.
  - Throughput: 1 per cycle while out_ready=1.
- FSM (state encodes occupancy):
  - EMPTY: in_ready=1, out_valid=0. On input transfer, load output regs and go to ONE.
  - ONE: in_ready=1, out_valid=1.
    - input & output transfer: load output regs, stay ONE.
    - output only: go to EMPTY.
    - input only: load skid, go to FULL.
  - FULL: in_ready=0, out_valid=1.
    - On output transfer: move skid to output regs, go to ONE.
- Output stability: while out_valid=1 & out_ready=0, all out_* hold stable.
- Reset mid-operation: rst has priority over every transfer. Entries in flight are dropped and the FSM returns to EMPTY on the next edge.
- Immediate formation (opcode = ir[6:0]); sign source is always ir[31], extended to XLEN:
  - I (0010011, 0000011, 1100111, 0001111, 1110011): {ir[31:20]}, sign-extended.
  - S (0100011): {ir[31:25], ir[11:7]}, sign-extended.
  - B (1100011): {ir[31], ir[7], ir[30:25], ir[11:8], 0}, sign-extended.
  - U (0110111, 0010111): {ir[31:12], 12'b0}. For XLEN=64, bits 63:32 take the sign of ir[31].
  - J (1101111): {ir[31], ir[19:12], ir[20], ir[30:21], 0}, sign-extended.
  - R (0110011): imm=0, fmt=R.
  - Any other opcode, or ir[1:0]!=2'b11: imm=0, fmt=R, out_illegal=1.
- Target arithmetic:
  - Modulo 2^XLEN; wraps silently.
  - JALR target = in_pc + 4. The register-relative target is computed in execute, not here.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: for opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI):
  - out_imm = zero-extended ir[19:15];
  - out_fmt = Z (6).
- Undefined: every 1110011 instruction uses I-format; tag 6 is never produced.

Decomposition:
- Shared package holds:
  - opcode constants (OPC_ARITH_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_FENCE, OPC_OP);
  - the 3-bit format-tag enum;
  - FSM state encoding.
- One natural sub-module: imm_decode_comb.
  - Pure combinational; maps ir to {imm, fmt, illegal}; parametrised by XLEN.
  - Instantiated once, ahead of the output/skid registers.

Test Plan:
- Reset, then in_pc=0x100, in_ir=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I, target=0x104, illegal=0.
- in_ir=0xFE112E23 (sw x1,-4(x2)) -> imm=0xFFFFFFFC, fmt=S. With XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
- in_pc=0x100, in_ir=0xFE000CE3 (beq x0,x0,-8) -> imm=0xFFFFFFF8, fmt=B, target=0x000000F8. Then in_ir=0x123452B7 (lui x5,0x12345) -> imm=0x12345000, fmt=U.
- Back-pressure: hold out_ready=0 and stream 3 instructions -> in_ready drops after the 2nd accept, outputs hold stable. Release out_ready -> results emerge in order, none lost or duplicated.
- in_ir=0x0000007F -> illegal=1, imm=0. With IMM_GEN_ZICSR_EN, in_ir=0x3401D073 (csrrwi mstatus-style, zimm=3) -> imm=3, fmt=Z. Without the macro -> fmt=I, imm=0x340.
- Assert rst while in FULL -> next cycle out_valid=0, in_ready=1. No stale result appears after rst is released.
